// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16-entry receive FIFO between uart_rx and the ISA read path (0x306 data, 0x307 status/control).
// Define UART_RX_FIFO_IRQ_EN to get the ie control bit and the registered irq output; otherwise irq is tied low.
module uart_rx_fifo #(
   parameter int         DEPTH_LOG2 = 4,
   parameter logic [9:0] DATA_ADDR  = 10'h306,
   parameter logic [9:0] STAT_ADDR  = 10'h307
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       data_strobe,
   input  logic [9:0] ab,
   input  logic       aen,
   input  logic       ior_n,
   input  logic       iow_n,
   input  logic [7:0] db_in,
   output logic [7:0] db_out,
   output logic       oe_n,
   output logic       irq
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   typedef enum logic [1:0] {IDLE, RD_DATA, RD_STAT} state_t;
   state_t                r_state, w_state_nx;
   logic [2:0]            r_ior, r_iow, r_stb;
   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wp, r_rp;
   logic [CW-1:0]         r_count;
   logic                  r_ovr;
   logic                  w_cs_data, w_cs_stat, w_ior_fall, w_ior_rise, w_iow_rise, w_stb_fall;
   logic                  w_empty, w_full, w_pop, w_push, w_flush, w_ctrl_wr, w_unused;
   logic [7:0]            w_status, w_db_nx;

   assign w_cs_data  = (ab == DATA_ADDR) && !aen;
   assign w_cs_stat  = (ab == STAT_ADDR) && !aen;
   assign oe_n       = ior_n | !(w_cs_data | w_cs_stat);
   assign w_ior_fall = !r_ior[1] & r_ior[2];
   assign w_ior_rise = r_ior[1] & !r_ior[2];
   assign w_iow_rise = r_iow[1] & !r_iow[2];
   assign w_stb_fall = !r_stb[1] & r_stb[2];
   assign w_empty    = r_count == '0;
   assign w_full     = r_count == CW'(DEPTH);
   assign w_pop      = (r_state == RD_DATA) && w_ior_rise && !w_empty;
   // a pop in the same cycle frees the slot, so a push into a full FIFO is still accepted
   assign w_push     = w_stb_fall && (!w_full || w_pop);
   assign w_ctrl_wr  = w_iow_rise && w_cs_stat;
   assign w_flush    = w_ctrl_wr && db_in[0];
   assign w_status   = {5'(r_count), r_ovr, w_full, !w_empty};

   // bits [1:0] are the two synchroniser stages, bit [2] the previous synced value for edge detect
   always_ff @(posedge clk)
      if (rst) begin
         r_ior <= '1;
         r_iow <= '1;
         r_stb <= '0;
      end else begin
         r_ior <= {r_ior[1:0], ior_n};
         r_iow <= {r_iow[1:0], iow_n};
         r_stb <= {r_stb[1:0], data_strobe};
      end

   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= rx_data;

   always_ff @(posedge clk)
      if (rst || w_flush) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_ovr   <= 1'b0;
      end else begin
         if (w_push) r_wp <= r_wp + DEPTH_LOG2'(1);
         if (w_pop) r_rp <= r_rp + DEPTH_LOG2'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_stb_fall && !w_push) r_ovr <= 1'b1;
      end

   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else r_state <= w_state_nx;

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    w_state_nx = !w_ior_fall ? IDLE : w_cs_data ? RD_DATA : w_cs_stat ? RD_STAT : IDLE;
         RD_DATA,
         RD_STAT: w_state_nx = w_ior_rise ? IDLE : r_state;
         default: w_state_nx = IDLE;
      endcase
   end

   always_comb begin
      w_db_nx = db_out;
      if (r_state == IDLE && w_ior_fall)
         w_db_nx = w_cs_data ? (w_empty ? 8'h00 : r_mem[r_rp]) : w_cs_stat ? w_status : db_out;
   end

   always_ff @(posedge clk)
      if (rst) db_out <= 8'h00;
      else db_out <= w_db_nx;

`ifdef UART_RX_FIFO_IRQ_EN
   logic r_ie;
   assign w_unused = &{1'b0, db_in[7:2]};
   always_ff @(posedge clk)
      if (rst) begin
         r_ie <= 1'b0;
         irq  <= 1'b0;
      end else begin
         if (w_ctrl_wr) r_ie <= db_in[1];
         irq <= r_ie & !w_empty;
      end
`else
   assign w_unused = &{1'b0, db_in[7:1]};
   assign irq      = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: table-driven bench with a read-data scoreboard for uart_rx_fifo.
// Irq expectations follow UART_RX_FIFO_IRQ_EN, so the same bench covers both builds.
module tb_uart_rx_fifo;
   localparam logic [9:0] DA = 10'h306;
   localparam logic [9:0] SA = 10'h307;
`ifdef UART_RX_FIFO_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif
   logic       clk = 1'b0, rst = 1'b1;
   logic [7:0] rx_data = 8'h00, db_in = 8'h00, db_out;
   logic       data_strobe = 1'b1, aen = 1'b0, ior_n = 1'b1, iow_n = 1'b1, oe_n, irq;
   logic [9:0] ab = 10'h000;

   always #5 clk = ~clk;

   uart_rx_fifo dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .data_strobe(data_strobe), .ab(ab), .aen(aen),
      .ior_n(ior_n), .iow_n(iow_n), .db_in(db_in), .db_out(db_out), .oe_n(oe_n), .irq(irq)
   );

   typedef enum logic [1:0] {OP_PUSH, OP_RD, OP_WR} op_e;
   typedef struct {op_e op; logic [9:0] addr; logic [7:0] data; logic [7:0] exp;} vec_t;
   vec_t       tbl[$];
   logic [7:0] sb_q[$];
   int         n_vec = 0, n_bad = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic add(input op_e op, input logic [9:0] a, input logic [7:0] d, input logic [7:0] e);
      vec_t v;
      v.op = op; v.addr = a; v.data = d; v.exp = e;
      tbl.push_back(v);
   endtask

   task automatic push(input logic [7:0] b);
      rx_data = b;
      data_strobe = 1'b0;
      tick(3);
      data_strobe = 1'b1;
      tick(3);
   endtask

   task automatic rd_start(input logic [9:0] a, input logic [7:0] e, input string nm);
      sb_q.push_back(e);
      ab = a; aen = 1'b0; ior_n = 1'b0;
      tick(1);
      chk({nm, "_oe_on"}, {7'b0, oe_n}, 8'h00);
      tick(4);
   endtask

   task automatic rd_sample(input string nm);
      if (sb_q.size() == 0) begin
         n_vec++; n_bad++;
         $display("FAIL %s: scoreboard empty, got %h", nm, db_out);
      end else chk(nm, db_out, sb_q.pop_front());
   endtask

   task automatic rd_end(input string nm);
      ior_n = 1'b1;
      tick(1);
      chk({nm, "_oe_off"}, {7'b0, oe_n}, 8'h01);
      tick(5);
   endtask

   task automatic rd(input logic [9:0] a, input logic [7:0] e, input string nm);
      rd_start(a, e, nm);
      rd_sample(nm);
      rd_end(nm);
   endtask

   task automatic wr(input logic [9:0] a, input logic [7:0] d);
      ab = a; aen = 1'b0; db_in = d; iow_n = 1'b0;
      tick(4);
      iow_n = 1'b1;
      tick(5);
   endtask

   initial begin
      add(OP_RD, SA, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) add(OP_PUSH, DA, 8'h41 + 8'(i), 8'h00);
      for (int i = 0; i < 3; i++) add(OP_RD, DA, 8'h00, 8'h41 + 8'(i));
      add(OP_RD, SA, 8'h00, 8'h00);
      for (int i = 0; i < 17; i++) add(OP_PUSH, DA, 8'(i), 8'h00);
      add(OP_RD, SA, 8'h00, 8'h87);
      for (int i = 0; i < 16; i++) add(OP_RD, DA, 8'h00, 8'(i));
      add(OP_RD, SA, 8'h00, 8'h04);
      add(OP_WR, SA, 8'h01, 8'h00);
      add(OP_RD, SA, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++) add(OP_PUSH, DA, 8'hA0 + 8'(i), 8'h00);
      add(OP_RD, SA, 8'h00, 8'h29);
      add(OP_WR, SA, 8'h01, 8'h00);
      add(OP_RD, SA, 8'h00, 8'h00);
      add(OP_RD, DA, 8'h00, 8'h00);
      add(OP_RD, SA, 8'h00, 8'h00);
      add(OP_PUSH, DA, 8'h77, 8'h00);
      add(OP_RD, DA, 8'h00, 8'h77);
      add(OP_PUSH, DA, 8'h5A, 8'h00);
      add(OP_WR, DA, 8'h01, 8'h00);
      add(OP_RD, SA, 8'h00, 8'h09);
      add(OP_RD, DA, 8'h00, 8'h5A);

      tick(3);
      rst = 1'b0;
      tick(2);
      chk("reset_db", db_out, 8'h00);
      chk("reset_irq", {7'b0, irq}, 8'h00);
      chk("reset_oe", {7'b0, oe_n}, 8'h01);

      foreach (tbl[i])
         case (tbl[i].op)
            OP_PUSH: push(tbl[i].data);
            OP_WR:   wr(tbl[i].addr, tbl[i].data);
            default: rd(tbl[i].addr, tbl[i].exp, $sformatf("v%0d_rd%h", i, tbl[i].addr));
         endcase

      // aen high: no decode, no driver enable, no pop
      push(8'h33);
      ab = DA; aen = 1'b1; ior_n = 1'b0;
      tick(1);
      chk("aen_oe", {7'b0, oe_n}, 8'h01);
      tick(4);
      ior_n = 1'b1;
      tick(6);
      rd(SA, 8'h09, "aen_stat");
      rd(DA, 8'h33, "aen_data");

      // full FIFO: push lands in the same cycle as the pop
      for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
      rd_start(DA, 8'h10, "full_rd");
      rd_sample("full_rd");
      rx_data = 8'hEE; data_strobe = 1'b0; ior_n = 1'b1;
      tick(3);
      data_strobe = 1'b1;
      tick(3);
      rd(SA, 8'h83, "full_pushpop_stat");
      rd(DA, 8'h11, "full_next");
      wr(SA, 8'h01);
      rd(SA, 8'h00, "full_flush_stat");

      // interrupt
      wr(SA, 8'h02);
      chk("irq_empty", {7'b0, irq}, 8'h00);
      rx_data = 8'h55; data_strobe = 1'b0;
      tick(3);
      chk("irq_not_yet", {7'b0, irq}, 8'h00);
      data_strobe = 1'b1;
      tick(1);
      chk("irq_rise", {7'b0, irq}, {7'b0, IRQ_ON});
      tick(2);
      rd(DA, 8'h55, "irq_data");
      chk("irq_fall", {7'b0, irq}, 8'h00);
      wr(SA, 8'h00);

      // reset in the middle of a data read
      push(8'h99);
      rd_start(DA, 8'h99, "rst_rd");
      rd_sample("rst_rd");
      rst = 1'b1;
      tick(2);
      chk("rst_mid_db", db_out, 8'h00);
      chk("rst_mid_irq", {7'b0, irq}, 8'h00);
      rst = 1'b0;
      ior_n = 1'b1;
      tick(6);
      rd(SA, 8'h00, "rst_stat");
      rd(DA, 8'h00, "rst_empty");
      chk("sb_drained", 8'(sb_q.size()), 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer between the serial receiver (`uart_rx`, 9600 baud) and the ISA bus read path. It captures each byte the receiver strobes out into a 16-entry FIFO, so bursts are not lost while the host services irq11. The host reads bytes at I/O 0x306 and status/control at 0x307. All logic runs on `clk`; ISA strobes and `data_strobe` are synchronised internally.

## Interface
Parameters:
- `DEPTH_LOG2`, 4 — FIFO depth is 2^DEPTH_LOG2 entries (16).
- `DATA_ADDR`, 10'h306 — read pops one received byte.
- `STAT_ADDR`, 10'h307 — read gives status; write gives control.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  byte from `uart_rx`; stable across the falling edge of `data_strobe`.
- `data_strobe`  in  1  receiver strobe; its falling edge means `rx_data` is valid. Asynchronous to `clk`.
- `ab`  in  10  ISA address.
- `aen`  in  1  ISA DMA address enable; decode only when 0.
- `ior_n`, `iow_n`  in  1  ISA read and write strobes, active low, asynchronous.
- `db_in`  in  8  ISA write data.
- `db_out`  out  8  ISA read data (registered).
- `oe_n`  out  1  bus driver enable, active low.
- `irq`  out  1  level interrupt to irq11 (registered).

## Operation
Synchronisation and decode:
- `ior_n`, `iow_n` and `data_strobe` each pass through a 2-FF synchroniser, then an edge-detect register.
- `cs_data` = (ab==DATA_ADDR && !aen). `cs_stat` = (ab==STAT_ADDR && !aen).
- `oe_n` = ior_n | !(cs_data|cs_stat). This path is combinational from the raw pins.

FIFO:
- Write pointer, read pointer (DEPTH_LOG2 bits each) and `count` (DEPTH_LOG2+1 bits, range 0..16). Pointers wrap modulo depth.
- Push: on a detected falling edge of `data_strobe`, write `rx_data` at the write pointer.
- Full push: data is dropped, pointers are unchanged, and sticky `ovr` is set.

Read FSM states: IDLE, RD_DATA, RD_STAT.
- IDLE → RD_DATA on a synced `ior_n` falling edge with `cs_data`.
  - Non-empty: `db_out` ← head entry.
  - Empty: `db_out` ← 8'h00.
- IDLE → RD_STAT on a synced `ior_n` falling edge with `cs_stat`.
  - `db_out` ← {count[4:0], ovr, full, !empty}.
- RD_DATA → IDLE on a synced `ior_n` rising edge. Pop one entry if non-empty; an empty read pops nothing.
- RD_STAT → IDLE on a synced `ior_n` rising edge.
- The address is sampled only at the falling edge, so address changes during the strobe are ignored.

Control write (synced `iow_n` rising edge with `cs_stat`):
- db_in[0]=1: flush. Pointers and `count` go to 0 and `ovr` clears.
- db_in[1]: sets interrupt enable `ie`.
- Writes to DATA_ADDR are ignored.

Simultaneous events:
- Push and pop in the same cycle: both happen and `count` is unchanged. This includes the full case: the pop frees a slot, so the push is accepted and `ovr` is not set.
- Flush and push in the same cycle: flush wins and the byte is discarded.
- Flush during RD_DATA: the later pop sees an empty FIFO and does nothing.

Interrupt: `irq` ← ie & !empty, registered.

Reset: pointers, `count`, `ovr` and `ie` go to 0; FSM goes to IDLE; `db_out` = 8'h00; `irq` = 0. FIFO RAM contents are don't-care. Reset asserted mid-read returns the FSM to IDLE and no pop occurs.

## Timing
- Push: `count` updates 3 clk after the `data_strobe` falling edge (2 sync + 1 edge detect).
- Read data: `db_out` valid 4 clk after `ior_n` falls. The ISA strobe must be at least 4 clk plus setup long; at 50 MHz that is 80 ns, well inside a standard 8-bit I/O cycle.
- Pop: takes effect 3 clk after `ior_n` rises.
- `irq`: rises 1 clk after `count` leaves 0; falls 1 clk after the pop that empties the FIFO.
- Throughput: one push per 4 clk is the minimum `data_strobe` period supported; the UART rate is far below this.

## Configuration
- `UART_RX_FIFO_IRQ_EN` defined: `irq` behaves as described and `ie` is writable.
- Not defined: `irq` is tied to 0, `ie` is not implemented, and db_in[1] is ignored. The host polls status bit0.

## Test plan
- Reset, then read 0x307 → db_out=8'h00; `irq`=0; `oe_n`=0 only while `ior_n` is low.
- Push 0x41, 0x42, 0x43, then read 0x306 three times → 0x41, 0x42, 0x43; then status=8'h00.
- Push 17 bytes 0x00..0x10 → status = {5'd16, 1, 1, 1} = 8'h87. Reads return 0x00..0x0F; 0x10 is lost.
- Fill to 16, then align a push with a pop's rising-edge cycle → `count` stays 16 and `ovr` stays 0.
- Write 0x307 = 0x02, push 0x55 → `irq`=1 3–4 clk later; read 0x306 → `irq`=0 after the pop. Repeat without the macro → `irq` never asserts.
- Push 5 bytes, write 0x307 = 0x01 → status=8'h00; the next read 0x306 returns 0x00 with no pointer movement.
